egress_grant: RTL and testbench
===============================

Name: egress_grant

Overview:
- Egress-side grant arbiter of the 4x4 VOQ crossbar scheduler; one instance per egress port.
- Each ingress proposes to egresses by picking a non-empty, non-taken VOQ. This block receives those requests, grants one ingress in round-robin order, waits for that ingress to accept, and holds the match for the whole packet transfer.
- Round-robin pointer advances only on an accepted grant (iSLIP rule), so service stays fair across epochs.

Parameters:
- N_PORTS, 4, number of ingress ports; index width is 2 bits, fixed for this switch.
- ACCEPT_TIMEOUT, 3, cycles a grant waits for accept before it counts as declined (1..15).
- MAX_ITER, 2, grant attempts per scheduling epoch (1..4).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sched_start  in  1  one-cycle pulse that opens a scheduling epoch
- egress_busy  in  1  egress output cannot take a new packet
- ingress_req  in  4  bit i = ingress i requests this egress
- ingress_accept  in  4  bit i = ingress i accepts this egress's grant
- xfer_done  in  1  one-cycle pulse marking the end of the matched packet transfer
- grant_valid  out  1  grant currently offered or held
- grant_idx  out  2  granted ingress index
- grant_onehot  out  4  one-hot form of grant_idx, zero when grant_valid=0
- matched  out  1  grant accepted, transfer in progress
- no_match  out  1  one-cycle pulse: epoch ended without a match
- rr_ptr  out  2  current round-robin priority pointer

Behaviour:
- Reset (async, reset_n=0): state IDLE; grant_valid=0, grant_idx=0, grant_onehot=0, matched=0, no_match=0, rr_ptr=0; declined mask, iteration count and timeout counter all cleared. Reset mid-transfer drops the match immediately; there is no recovery of in-flight state.
- All outputs are registered.
- States: IDLE, WAIT_ACCEPT, XFER.
- Pick function: the first index j in rr_ptr, rr_ptr+1, ... (mod 4) with ingress_req[j]=1 and declined[j]=0. Wrap-around: rr_ptr=3 checks 3,0,1,2.
- IDLE:
  - On sched_start=1, egress_busy=0 and a candidate exists: latch grant_idx, set grant_valid, set iter=1, clear the declined mask, load the timeout counter, go to WAIT_ACCEPT. grant_valid is high from the next edge (latency 1).
  - On sched_start=1, egress_busy=0 and ingress_req=0: pulse no_match next cycle, stay IDLE.
  - sched_start with egress_busy=1: ignored, no no_match pulse.
- WAIT_ACCEPT:
  - ingress_accept[grant_idx]=1 → matched=1, rr_ptr=grant_idx+1 (mod 4), go to XFER.
  - Accepts from non-granted ingresses are ignored.
  - Decline occurs on timeout (ACCEPT_TIMEOUT cycles spent in WAIT_ACCEPT without accept) or when ingress_req[grant_idx] drops. On decline, set declined[grant_idx].
    - If iter<MAX_ITER and a new candidate exists: switch grant_idx to it on the next edge, keep grant_valid=1, iter+1, reload the timeout counter.
    - Otherwise: grant_valid=0, pulse no_match, go to IDLE. rr_ptr is unchanged.
  - Accept and timeout in the same cycle: accept wins.
- XFER:
  - Hold grant_valid, grant_idx and matched. ingress_req and sched_start are ignored.
  - On xfer_done: grant_valid=0, matched=0, go to IDLE on the next edge.
  - A new sched_start is honoured only once the block is back in IDLE.
- xfer_done outside XFER is ignored.

Test Plan:
- Reset, then rr_ptr=0, ingress_req=4'b0110, sched_start → grant_idx=1 one cycle later. Accept bit1 → matched=1, rr_ptr=2. xfer_done → grant_valid=0, back to IDLE.
- rr_ptr=3 (set by a prior accept of ingress 2), ingress_req=4'b0101, sched_start → grant_idx=0 (wrap-around). Accept → rr_ptr=1.
- ingress_req=4'b0011, rr_ptr=0, no accept → grant 0 for 3 cycles, then grant_idx=1. Accept bit1 on the same cycle its timeout expires → matched=1, rr_ptr=2.
- ingress_req=4'b0001, MAX_ITER=2, never accept → after 3 cycles no_match pulses once, grant_valid=0, rr_ptr unchanged.
- sched_start with egress_busy=1 → no grant, no no_match. sched_start with ingress_req=0 → no_match pulse only.
- reset_n low during XFER → grant_valid, matched and rr_ptr are 0 without waiting for a clock edge. Accept from a non-granted ingress in WAIT_ACCEPT → ignored.

Source files
------------

// File: rtl/egress_grant.sv
// Egress-side grant arbiter for one output of the 4x4 VOQ crossbar scheduler.
// Grants one requesting ingress round-robin, waits for its accept, then holds the match until xfer_done.
module egress_grant #(
  parameter int N_PORTS        = 4,
  parameter int ACCEPT_TIMEOUT = 3,
  parameter int MAX_ITER       = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               sched_start,
  input  logic               egress_busy,
  input  logic [N_PORTS-1:0] ingress_req,
  input  logic [N_PORTS-1:0] ingress_accept,
  input  logic               xfer_done,
  output logic               grant_valid,
  output logic [1:0]         grant_idx,
  output logic [N_PORTS-1:0] grant_onehot,
  output logic               matched,
  output logic               no_match,
  output logic [1:0]         rr_ptr,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_ACCEPT = 2'd1, XFER = 2'd2} state_t;

  state_t       r_state, w_state_nxt;
  logic         r_grant_valid, w_valid_nxt;
  logic [1:0]   r_grant_idx, w_idx_nxt;
  logic [3:0]   r_grant_onehot, w_onehot_nxt;
  logic         r_matched, w_matched_nxt;
  logic         r_no_match, w_no_match_nxt;
  logic [1:0]   r_rr_ptr, w_ptr_nxt;
  logic [3:0]   r_declined, w_declined_nxt;
  logic [2:0]   r_iter, w_iter_nxt;
  logic [3:0]   r_timer, w_timer_nxt;
  logic [2:0]   w_pick_idle, w_pick_retry;

  // Returns {found, index}: first requesting, non-declined ingress starting at ptr.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [3:0] mask,
                                      input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] j;
    res = 3'b000;
    for (int d = 3; d >= 0; d--) begin
      j = ptr + 2'(d);
      if (req[j] && !mask[j]) res = {1'b1, j};
    end
    return res;
  endfunction

  assign w_pick_idle  = pick(ingress_req, 4'b0000, r_rr_ptr);
  assign w_pick_retry = pick(ingress_req, r_declined | r_grant_onehot, r_rr_ptr);

  // Handshake: grant_valid/grant_idx is the offer; ingress_accept[grant_idx] high in a
  // WAIT_ACCEPT cycle completes it at that edge, and the match then holds until xfer_done.
  always_comb begin
    w_state_nxt    = r_state;
    w_valid_nxt    = r_grant_valid;
    w_idx_nxt      = r_grant_idx;
    w_matched_nxt  = r_matched;
    w_no_match_nxt = 1'b0;
    w_ptr_nxt      = r_rr_ptr;
    w_declined_nxt = r_declined;
    w_iter_nxt     = r_iter;
    w_timer_nxt    = r_timer;
    case (r_state)
      IDLE: begin
        if (sched_start && !egress_busy) begin
          if (w_pick_idle[2]) begin
            w_state_nxt    = WAIT_ACCEPT;
            w_valid_nxt    = 1'b1;
            w_idx_nxt      = w_pick_idle[1:0];
            w_iter_nxt     = 3'd1;
            w_declined_nxt = 4'b0000;
            w_timer_nxt    = 4'(ACCEPT_TIMEOUT - 1);
          end else begin
            w_no_match_nxt = 1'b1;
          end
        end
      end
      WAIT_ACCEPT: begin
        if (ingress_accept[r_grant_idx]) begin
          w_matched_nxt = 1'b1;
          w_ptr_nxt     = r_grant_idx + 2'd1;
          w_state_nxt   = XFER;
        end else if (r_timer == 4'd0 || !ingress_req[r_grant_idx]) begin
          w_declined_nxt = r_declined | r_grant_onehot;
          if (r_iter < 3'(MAX_ITER) && w_pick_retry[2]) begin
            w_idx_nxt   = w_pick_retry[1:0];
            w_iter_nxt  = r_iter + 3'd1;
            w_timer_nxt = 4'(ACCEPT_TIMEOUT - 1);
          end else begin
            w_valid_nxt    = 1'b0;
            w_no_match_nxt = 1'b1;
            w_state_nxt    = IDLE;
          end
        end else begin
          w_timer_nxt = r_timer - 4'd1;
        end
      end
      XFER: begin
        if (xfer_done) begin
          w_valid_nxt   = 1'b0;
          w_matched_nxt = 1'b0;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_onehot_nxt = w_valid_nxt ? (4'b0001 << w_idx_nxt) : 4'b0000;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_grant_valid  <= 1'b0;
      r_grant_idx    <= 2'd0;
      r_grant_onehot <= 4'b0000;
      r_matched      <= 1'b0;
      r_no_match     <= 1'b0;
      r_rr_ptr       <= 2'd0;
      r_declined     <= 4'b0000;
      r_iter         <= 3'd0;
      r_timer        <= 4'd0;
    end else begin
      r_state        <= w_state_nxt;
      r_grant_valid  <= w_valid_nxt;
      r_grant_idx    <= w_idx_nxt;
      r_grant_onehot <= w_onehot_nxt;
      r_matched      <= w_matched_nxt;
      r_no_match     <= w_no_match_nxt;
      r_rr_ptr       <= w_ptr_nxt;
      r_declined     <= w_declined_nxt;
      r_iter         <= w_iter_nxt;
      r_timer        <= w_timer_nxt;
    end
  end

  assign grant_valid  = r_grant_valid;
  assign grant_idx    = r_grant_idx;
  assign grant_onehot = r_grant_onehot;
  assign matched      = r_matched;
  assign no_match     = r_no_match;
  assign rr_ptr       = r_rr_ptr;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_egress_grant.sv
// Bench for egress_grant: directed scenarios plus random epochs against an epoch-level model.
module tb_egress_grant;
  localparam int TO       = 3;
  localparam int MAX_ITER = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       sched_start, egress_busy, xfer_done;
  logic [3:0] ingress_req, ingress_accept;
  logic       grant_valid, matched, no_match;
  logic [1:0] grant_idx, rr_ptr, dbg_state;
  logic [3:0] grant_onehot;

  int tests = 0;
  int fails = 0;
  int exp_ptr = 0;

  egress_grant #(.N_PORTS(4), .ACCEPT_TIMEOUT(TO), .MAX_ITER(MAX_ITER)) dut (
    .clk(clk), .reset_n(reset_n), .sched_start(sched_start), .egress_busy(egress_busy),
    .ingress_req(ingress_req), .ingress_accept(ingress_accept), .xfer_done(xfer_done),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .grant_onehot(grant_onehot),
    .matched(matched), .no_match(no_match), .rr_ptr(rr_ptr), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Complete a held match: a few idle cycles, then xfer_done.
  task automatic finish_xfer(input int g);
    int hold;
    hold = $urandom_range(0, 3);
    for (int h = 0; h < hold; h++) begin
      ingress_req = 4'($urandom);
      sched_start = 1'($urandom);
      step();
      check("xfer_hold_matched", 32'(matched), 1);
      check("xfer_hold_idx", 32'(grant_idx), 32'(g));
    end
    sched_start = 1'b0;
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    check("done_valid", 32'(grant_valid), 0);
    check("done_matched", 32'(matched), 0);
    check("done_onehot", 32'(grant_onehot), 0);
  endtask

  // acc0/acc1: cycle within attempt 0/1 at which the granted ingress accepts (-1 = never).
  task automatic run_epoch(input logic [3:0] req, input int acc0, input int acc1);
    logic [3:0] declined;
    int acc[2];
    int g;
    bit found, done;
    acc[0] = acc0;
    acc[1] = acc1;
    declined = 4'b0000;
    done = 0;
    ingress_req = req;
    sched_start = 1'b1;
    step();
    sched_start = 1'b0;
    for (int k = 0; k < MAX_ITER && !done; k++) begin
      found = 0;
      g = 0;
      for (int d = 0; d < 4; d++)
        if (!found && req[(exp_ptr + d) % 4] && !declined[(exp_ptr + d) % 4]) begin
          found = 1;
          g = (exp_ptr + d) % 4;
        end
      if (!found) break;
      for (int c = 0; c < TO && !done; c++) begin
        check("grant_valid", 32'(grant_valid), 1);
        check("grant_idx", 32'(grant_idx), 32'(g));
        check("grant_onehot", 32'(grant_onehot), 32'(1 << g));
        check("not_matched", 32'(matched), 0);
        if (acc[k] == c) begin
          ingress_accept = 4'(1 << g) | 4'($urandom);
          step();
          ingress_accept = 4'b0000;
          exp_ptr = (g + 1) % 4;
          check("matched", 32'(matched), 1);
          check("rr_ptr_after_accept", 32'(rr_ptr), 32'(exp_ptr));
          check("matched_idx", 32'(grant_idx), 32'(g));
          finish_xfer(g);
          done = 1;
        end else begin
          ingress_accept = 4'($urandom) & ~4'(1 << g);
          step();
          ingress_accept = 4'b0000;
        end
      end
      declined[g] = 1'b1;
    end
    if (!done) begin
      check("no_match_pulse", 32'(no_match), 1);
      check("no_match_valid", 32'(grant_valid), 0);
      check("no_match_ptr", 32'(rr_ptr), 32'(exp_ptr));
      step();
      check("no_match_once", 32'(no_match), 0);
    end
    ingress_req = 4'b0000;
  endtask

  initial begin
    int r0, r1;
    reset_n = 1'b0;
    sched_start = 1'b0;
    egress_busy = 1'b0;
    xfer_done = 1'b0;
    ingress_req = 4'b0000;
    ingress_accept = 4'b0000;
    #1;
    check("rst_valid", 32'(grant_valid), 0);
    check("rst_idx", 32'(grant_idx), 0);
    check("rst_onehot", 32'(grant_onehot), 0);
    check("rst_matched", 32'(matched), 0);
    check("rst_no_match", 32'(no_match), 0);
    check("rst_ptr", 32'(rr_ptr), 0);
    step();
    step();
    reset_n = 1'b1;
    step();

    run_epoch(4'b0110, 0, -1);   // grant 1, rr_ptr -> 2
    run_epoch(4'b0100, 1, -1);   // grant 2, rr_ptr -> 3
    run_epoch(4'b0101, 0, -1);   // wrap: grant 0, rr_ptr -> 1
    run_epoch(4'b1000, 2, -1);   // grant 3, rr_ptr -> 0
    run_epoch(4'b0011, -1, 2);   // 0 times out, 1 accepts on its timeout cycle
    run_epoch(4'b0001, -1, -1);  // only candidate declines -> no_match

    // Request drop declines immediately; ptr is 2 so ingress 0 is granted first.
    ingress_req = 4'b0011;
    sched_start = 1'b1;
    step();
    sched_start = 1'b0;
    check("drop_first_idx", 32'(grant_idx), 0);
    ingress_req = 4'b0010;
    step();
    check("drop_valid", 32'(grant_valid), 1);
    check("drop_new_idx", 32'(grant_idx), 1);
    ingress_accept = 4'b0010;
    step();
    ingress_accept = 4'b0000;
    exp_ptr = 2;
    check("drop_matched", 32'(matched), 1);
    check("drop_ptr", 32'(rr_ptr), 2);
    finish_xfer(1);
    ingress_req = 4'b0000;

    // Busy egress ignores sched_start entirely.
    egress_busy = 1'b1;
    ingress_req = 4'b0011;
    sched_start = 1'b1;
    step();
    sched_start = 1'b0;
    check("busy_valid", 32'(grant_valid), 0);
    check("busy_no_match", 32'(no_match), 0);
    step();
    check("busy_valid2", 32'(grant_valid), 0);
    egress_busy = 1'b0;
    ingress_req = 4'b0000;
    sched_start = 1'b1;
    step();
    sched_start = 1'b0;
    check("empty_no_match", 32'(no_match), 1);
    check("empty_valid", 32'(grant_valid), 0);
    step();
    check("empty_no_match_once", 32'(no_match), 0);

    for (int e = 0; e < 30; e++) begin
      r0 = $urandom_range(0, 3);
      r1 = $urandom_range(0, 3);
      run_epoch(4'($urandom_range(1, 15)), (r0 == 3) ? -1 : r0, (r1 == 3) ? -1 : r1);
      step();
    end

    // Non-granted accept is ignored, then async reset during transfer.
    ingress_req = 4'b1010;
    sched_start = 1'b1;
    step();
    sched_start = 1'b0;
    check("ng_idx", 32'(grant_idx), 32'((exp_ptr <= 1) ? 1 : 3));
    ingress_accept = ~grant_onehot;
    step();
    check("ng_ignored", 32'(matched), 0);
    ingress_accept = grant_onehot;
    step();
    ingress_accept = 4'b0000;
    check("pre_rst_matched", 32'(matched), 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(grant_valid), 0);
    check("async_rst_matched", 32'(matched), 0);
    check("async_rst_ptr", 32'(rr_ptr), 0);
    exp_ptr = 0;
    ingress_req = 4'b0000;
    step();
    reset_n = 1'b1;
    step();
    run_epoch(4'b1001, 0, -1);   // post-reset: ptr 0 -> grant 0

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
